digit_accumulator: RTL and testbench
====================================

DIGIT_ACCUMULATOR -- requirements
Module: digit_accumulator

Interface
- REQ-001: Parameter UUID, default 0, instance identifier, XORed into child instance IDs.
- REQ-002: Parameter NAME, default "", instance label; no functional effect.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: in_valid  input  1  Input word present.
- REQ-006: in_last  input  1  qualifies the word as the final word of the stream; sampled with the word.
- REQ-007: in_ready  output  1  block can accept a word.
- REQ-008: Input  input  64  eight byte lanes of decoded digit values; lane k = bits [8k+7:8k]; lane 0 is processed first.
- REQ-009: out_valid  output  1  Output holds a completed number.
- REQ-010: out_ready  input  1  consumer accepts Output.
- REQ-011: Output  output  64  completed unsigned decimal number.

Function
- REQ-012: A lane value 0-9 SHALL be a digit; any lane value 10-255 SHALL be a separator.
- REQ-013: The FSM SHALL have states IDLE, SCAN and FLUSH; in_ready SHALL be 1 only in IDLE.
- REQ-014: A word SHALL be accepted in IDLE when in_valid=1; it SHALL be registered with in_last, lane index set to 0, and the FSM SHALL go to SCAN.
- REQ-015: SCAN SHALL process one lane per cycle, lanes 0 to 7 in order; without stalls, lane k of a word accepted in cycle T is processed in cycle T+1+k.
- REQ-016: Digit lane: acc <= acc*10 + digit, modulo 2^64 (silent wrap); has_digit <= 1.
- REQ-017: Separator lane with has_digit=1: Output <= acc, out_valid <= 1, acc <= 0, has_digit <= 0; out_valid is visible the cycle after the lane is processed.
- REQ-018: Separator lane with has_digit=0 SHALL be consumed with no output; consecutive separators SHALL emit nothing.
- REQ-019: acc and has_digit SHALL persist across words, so a number may span word boundaries.
- REQ-020: Output transfer occurs when out_valid=1 and out_ready=1; out_valid then clears unless a new emission occurs in the same cycle, in which case Output takes the new value and out_valid stays 1.
- REQ-021: While out_valid=1 and out_ready=0, SCAN SHALL stall: lane index, acc and has_digit hold, and Output stays stable.
- REQ-022: After lane 7 is processed, the FSM SHALL go to IDLE if the registered in_last=0.
- REQ-023: After lane 7 is processed with in_last=1, the FSM SHALL go to FLUSH.
- REQ-024: In FLUSH with has_digit=1, the block SHALL emit acc as in REQ-017, honouring the REQ-021 stall, then go to IDLE.
- REQ-025: In FLUSH with has_digit=0, the block SHALL go to IDLE immediately.
- REQ-026: After FLUSH completes, acc=0 and has_digit=0.
- REQ-027: Maximum throughput SHALL be one word per 9 cycles, or 10 cycles when in_last=1.

Reset
- REQ-028: With rst=1 at a clock edge, the next state SHALL be: FSM IDLE, in_ready=1, out_valid=0, Output=0, acc=0, has_digit=0, lane index 0, registered word and in_last cleared.
- REQ-029: rst SHALL override all other inputs, including mid-SCAN, in FLUSH and with out_valid pending; partial digits and any pending output SHALL be discarded.

Verification
- REQ-030: Lanes [1,2,0,10,5,10,10,10], in_last=0, out_ready=1 -> Output 120 then Output 5; in_ready returns to 1 nine cycles after acceptance.
- REQ-031: Word A lanes [10,10,10,10,10,1,4,9], then word B lanes [6,9,10,10,10,10,10,10] -> single Output 14969.
- REQ-032: Lanes [7,10,10,10,10,10,4,2] with in_last=1 -> Output 7, then Output 42 from FLUSH; afterwards acc=0 and has_digit=0.
- REQ-033: Lanes [1,10,2,10,10,10,10,10] with out_ready=0 -> out_valid=1 with Output=1 held and lane index frozen; after out_ready=1 -> Output 2 with no number lost.
- REQ-034: Twenty digit-9 lanes then a separator -> Output 7766279631452241919, i.e. (10^20-1) mod 2^64.
- REQ-035: rst=1 in the cycle after lane 3 of [1,2,3,4,5,...] -> in_ready=1 and out_valid=0 the next cycle; the next word [8,10,...] yields Output 8.

Source files
------------

// File: rtl/digit_accumulator.sv
// Digit accumulator: scans eight byte lanes per word, folds runs of decimal
// digits into 64-bit unsigned numbers and emits each one on a ready/valid port.
module digit_accumulator #(
   parameter int UUID = 0,
   parameter     NAME = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   input  logic [63:0] Input,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] Output
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   // Leaf block: the identifiers are carried for hierarchy bookkeeping only.
   if ((UUID < 0) && (NAME == "")) begin : g_id_guard
   end

   // Multiply-accumulate one decimal digit, wrapping modulo 2^64.
   function automatic logic [63:0] mul10_add(input logic [63:0] acc, input logic [3:0] digit);
      mul10_add = (acc << 3) + (acc << 1) + {60'd0, digit};
   endfunction

   state_t      state_q, state_d;
   logic [63:0] word_q, word_d;
   logic        last_q, last_d;
   logic [2:0]  lane_q, lane_d;
   logic [63:0] acc_q, acc_d;
   logic        has_digit_q, has_digit_d;
   logic        out_valid_q, out_valid_d;
   logic [63:0] out_q, out_d;

   logic        stall_s;
   logic        accept_s;
   logic        lane_step_s;
   logic        flush_emit_s;
   logic        in_ready_s;
   logic [7:0]  lane_byte_s;
   logic        is_digit_s;
   logic        emit_s;

   // A pending, unaccepted result freezes all lane processing.
   assign stall_s     = out_valid_q & ~out_ready;
   assign lane_byte_s = word_q[{lane_q, 3'b000} +: 8];
   assign is_digit_s  = (lane_byte_s < 8'd10);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_SCAN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (!stall_s && (lane_q == 3'd7)) begin
               state_d = last_q ? ST_FLUSH : ST_IDLE;
            end else begin
               state_d = ST_SCAN;
            end
         end
         ST_FLUSH: begin
            if (!has_digit_q || !stall_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_FLUSH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM output decode: per-state control strobes.
   always_comb begin
      in_ready_s   = 1'b0;
      accept_s     = 1'b0;
      lane_step_s  = 1'b0;
      flush_emit_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready_s = 1'b1;
            accept_s   = in_valid;
         end
         ST_SCAN: begin
            lane_step_s = ~stall_s;
         end
         ST_FLUSH: begin
            flush_emit_s = has_digit_q & ~stall_s;
         end
         default: begin
            in_ready_s = 1'b0;
         end
      endcase
   end

   assign emit_s = (lane_step_s & ~is_digit_s & has_digit_q) | flush_emit_s;

   // Datapath next-state: word capture, lane walk, accumulator and result port.
   always_comb begin
      word_d      = word_q;
      last_d      = last_q;
      lane_d      = lane_q;
      acc_d       = acc_q;
      has_digit_d = has_digit_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;

      if (accept_s) begin
         word_d = Input;
         last_d = in_last;
         lane_d = 3'd0;
      end else if (lane_step_s) begin
         lane_d = lane_q + 3'd1;
         if (is_digit_s) begin
            acc_d       = mul10_add(acc_q, lane_byte_s[3:0]);
            has_digit_d = 1'b1;
         end else if (has_digit_q) begin
            acc_d       = 64'd0;
            has_digit_d = 1'b0;
         end else begin
            acc_d       = acc_q;
            has_digit_d = has_digit_q;
         end
      end else if (flush_emit_s) begin
         acc_d       = 64'd0;
         has_digit_d = 1'b0;
      end else begin
         lane_d = lane_q;
      end

      // A fresh emission wins over a same-cycle transfer of the old value.
      if (emit_s) begin
         out_d       = acc_q;
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q      <= 64'd0;
         last_q      <= 1'b0;
         lane_q      <= 3'd0;
         acc_q       <= 64'd0;
         has_digit_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= 64'd0;
      end else begin
         word_q      <= word_d;
         last_q      <= last_d;
         lane_q      <= lane_d;
         acc_q       <= acc_d;
         has_digit_q <= has_digit_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_q;
   assign Output    = out_q;

endmodule

// File: tb/tb_digit_accumulator.sv
// Directed, table-driven bench for digit_accumulator with hand sequences for
// back-pressure and reset corner cases.
module tb_digit_accumulator;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [63:0] Input;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] Output;

   int          checks;
   int          failures;
   logic [63:0] got[$];

   typedef struct {
      logic [63:0] word;
      logic        last;
      int          n_exp;
      logic [63:0] exp0;
      logic [63:0] exp1;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   digit_accumulator #(.UUID(0), .NAME("tb")) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_last  (in_last),
      .in_ready (in_ready),
      .Input    (Input),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .Output   (Output)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every completed transfer (sampled mid-cycle, before the edge that takes it).
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) got.push_back(Output);
   end

   function automatic logic [63:0] pack8(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3,
                                         input logic [7:0] b4, input logic [7:0] b5,
                                         input logic [7:0] b6, input logic [7:0] b7);
      pack8 = {b7, b6, b5, b4, b3, b2, b1, b0};
   endfunction

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic send_word(input logic [63:0] w, input logic last);
      int n;
      n = 0;
      @(posedge clk); #1;
      while (!in_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check64("in_ready_wait", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      in_last  = last;
      Input    = w;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Cycles from acceptance until in_ready is seen again.
   task automatic measure_ready(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!in_ready && lat < 40);
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      Input     = 64'd0;
      out_ready = 1'b1;

      vecs[0] = '{pack8(8'd1, 8'd2, 8'd0, 8'd10, 8'd5, 8'd10, 8'd10, 8'd10), 1'b0, 2, 64'd120, 64'd5, 9};
      vecs[1] = '{pack8(8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd1, 8'd4, 8'd9), 1'b0, 0, 64'd0, 64'd0, 9};
      vecs[2] = '{pack8(8'd6, 8'd9, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10), 1'b0, 1, 64'd14969, 64'd0, 9};
      vecs[3] = '{pack8(8'd7, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd4, 8'd2), 1'b1, 2, 64'd7, 64'd42, 10};
      vecs[4] = '{pack8(8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9), 1'b0, 0, 64'd0, 64'd0, 9};
      vecs[5] = '{pack8(8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9), 1'b0, 0, 64'd0, 64'd0, 9};
      vecs[6] = '{pack8(8'd9, 8'd9, 8'd9, 8'd9, 8'd10, 8'd10, 8'd10, 8'd10), 1'b0, 1,
                  64'd7766279631452241919, 64'd0, 9};
      vecs[7] = '{pack8(8'd255, 8'd10, 8'd200, 8'd10, 8'd11, 8'd10, 8'd10, 8'd10), 1'b1, 0, 64'd0, 64'd0, 10};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check64("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check64("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check64("rst_output", Output, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         got.delete();
         send_word(vecs[i].word, vecs[i].last);
         measure_ready(lat);
         check64($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         settle();
         check64($sformatf("vec%0d_count", i), got.size(), vecs[i].n_exp);
         if (vecs[i].n_exp > 0 && got.size() > 0) check64($sformatf("vec%0d_out0", i), got[0], vecs[i].exp0);
         if (vecs[i].n_exp > 1 && got.size() > 1) check64($sformatf("vec%0d_out1", i), got[1], vecs[i].exp1);
         if (vecs[i].last) begin
            check64($sformatf("vec%0d_acc_clear", i), dut.acc_q, 64'd0);
            check64($sformatf("vec%0d_hasdig_clear", i), {63'd0, dut.has_digit_q}, 64'd0);
         end
      end

      // Back-pressure: first result held, lanes frozen, nothing lost on release.
      got.delete();
      out_ready = 1'b0;
      send_word(pack8(8'd1, 8'd10, 8'd2, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10), 1'b0);
      repeat (6) @(negedge clk);
      check64("stall_out_valid", {63'd0, out_valid}, 64'd1);
      check64("stall_output", Output, 64'd1);
      check64("stall_lane", {61'd0, dut.lane_q}, 64'd2);
      check64("stall_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      measure_ready(lat);
      settle();
      check64("stall_count", got.size(), 64'd2);
      if (got.size() > 1) begin
         check64("stall_out0", got[0], 64'd1);
         check64("stall_out1", got[1], 64'd2);
      end

      // Reset with a result pending discards it.
      out_ready = 1'b0;
      send_word(pack8(8'd5, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10), 1'b0);
      repeat (4) @(negedge clk);
      check64("pend_out_valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check64("pend_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check64("pend_rst_output", Output, 64'd0);
      check64("pend_rst_in_ready", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;

      // Reset mid-scan after lane 3 drops the partial number.
      send_word(pack8(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8), 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check64("scan_rst_in_ready", {63'd0, in_ready}, 64'd1);
      check64("scan_rst_out_valid", {63'd0, out_valid}, 64'd0);
      got.delete();
      send_word(pack8(8'd8, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10), 1'b0);
      measure_ready(lat);
      settle();
      check64("post_rst_count", got.size(), 64'd1);
      if (got.size() > 0) check64("post_rst_out", got[0], 64'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
